// File: rtl/onchip_mem_block_master_if.sv
// Avalon-MM initiator bus between the block master and the on-chip RAM s1 port.
interface onchip_mem_block_master_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;
  logic              avm_clken;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken,
    input  avm_readdata, avm_waitrequest
  );
  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/onchip_mem_block_master.sv
// Block mover between valid/ready streams and the on-chip RAM over Avalon-MM.
// Optional busy-cycle counter: define ONCHIP_MEM_BLOCK_MASTER_PERF_EN.
module onchip_mem_block_master #(
  parameter int DEPTH        = 10240,
  parameter int ADDR_W       = 14,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [31:0]       wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       perf_cycles,
  onchip_mem_block_master_if.master avm
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] rem;
  } cmd_t;

  state_t state, state_nxt;
  cmd_t   cur, cur_nxt;

  logic [READ_LATENCY:1] vld_pipe;
  logic [31:0]           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt, inflight;
  logic                  rd_issue, rd_acc, push, pop;
  logic                  cs_c, we_c, wr_ready_c;
  logic [31:0]           wd_c;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Reads in flight plus buffered words bound the issue rate, so returns always have a slot.
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= READ_LATENCY; i++) inflight = inflight + CNT_W'(vld_pipe[i]);
  end

  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur;
    cmd_ready  = 1'b0;
    wr_ready_c = 1'b0;
    rd_issue   = 1'b0;
    done       = 1'b0;
    cs_c       = 1'b0;
    we_c       = 1'b0;
    wd_c       = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_nxt.addr = cmd_addr;
          cur_nxt.rem  = cmd_len;
          if (cmd_len == '0) state_nxt = DONE;
          else               state_nxt = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready_c = ~avm.avm_waitrequest;
        cs_c       = wr_valid;
        we_c       = wr_valid;
        wd_c       = wr_data;
        if (wr_valid && !avm.avm_waitrequest) begin
          cur_nxt.addr = addr_inc(cur.addr);
          cur_nxt.rem  = cur.rem - ADDR_W'(1);
          if (cur.rem == ADDR_W'(1)) state_nxt = DONE;
        end
      end
      READ: begin
        rd_issue = (inflight + fifo_cnt) < CNT_W'(FIFO_DEPTH);
        cs_c     = rd_issue;
        if (rd_issue && !avm.avm_waitrequest) begin
          cur_nxt.addr = addr_inc(cur.addr);
          cur_nxt.rem  = cur.rem - ADDR_W'(1);
          if (cur.rem == ADDR_W'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: if (inflight == '0 && fifo_cnt == '0) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_acc = rd_issue & ~avm.avm_waitrequest;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cur      <= '0;
      vld_pipe <= '0;
    end else begin
      state       <= state_nxt;
      cur         <= cur_nxt;
      vld_pipe[1] <= rd_acc;
      for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Return buffer: no backpressure toward the RAM, capture is unconditional.
  assign push     = vld_pipe[READ_LATENCY];
  assign rd_valid = (fifo_cnt != '0);
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = rd_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= avm.avm_readdata;
  end

  // Strobes are masked by reset so the bus goes quiet in the cycle reset is sampled.
  assign avm.avm_chipselect = cs_c & ~reset;
  assign avm.avm_write      = we_c & ~reset;
  assign avm.avm_writedata  = wd_c;
  assign avm.avm_address    = cur.addr;
  assign avm.avm_byteenable = 4'hF;
  assign avm.avm_clken      = 1'b1;
  assign wr_ready           = wr_ready_c & ~reset;
  assign busy               = (state != IDLE);

`ifdef ONCHIP_MEM_BLOCK_MASTER_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk) begin
    if (reset)                       perf_q <= '0;
    else if (cmd_valid && cmd_ready) perf_q <= '0;
    else if (busy && perf_q != '1)   perf_q <= perf_q + 32'd1;
  end
  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule
